// File: rtl/tour_pkg.sv
// Shared state encoding, board type and knight-move geometry for the 5x5 tour solver.
package tour_pkg;

    typedef enum logic [1:0] {IDLE, POSSIBLE, MAKE_MOVE, BACKUP} state_t;

    // board[x][y] holds 0 for unvisited, otherwise the 1-based visit order
    typedef logic [0:4][0:4][4:0] board_t;

    localparam logic [4:0] LAST_MOVE = 5'd23;
    localparam logic [2:0] BOARD_MAX = 3'd4;

    localparam logic [7:0] MOVE_0 = 8'h01;
    localparam logic [7:0] MOVE_1 = 8'h02;
    localparam logic [7:0] MOVE_2 = 8'h04;
    localparam logic [7:0] MOVE_3 = 8'h08;
    localparam logic [7:0] MOVE_4 = 8'h10;
    localparam logic [7:0] MOVE_5 = 8'h20;
    localparam logic [7:0] MOVE_6 = 8'h40;
    localparam logic [7:0] MOVE_7 = 8'h80;

    function automatic logic signed [2:0] off_x(input logic [7:0] mv);
        case (mv)
            MOVE_0:  off_x = 3'sd1;
            MOVE_1:  off_x = -3'sd1;
            MOVE_2:  off_x = -3'sd2;
            MOVE_3:  off_x = -3'sd2;
            MOVE_4:  off_x = -3'sd1;
            MOVE_5:  off_x = 3'sd1;
            MOVE_6:  off_x = 3'sd2;
            MOVE_7:  off_x = 3'sd2;
            default: off_x = 3'sd0;
        endcase
    endfunction

    function automatic logic signed [2:0] off_y(input logic [7:0] mv);
        case (mv)
            MOVE_0:  off_y = 3'sd2;
            MOVE_1:  off_y = 3'sd2;
            MOVE_2:  off_y = 3'sd1;
            MOVE_3:  off_y = -3'sd1;
            MOVE_4:  off_y = -3'sd2;
            MOVE_5:  off_y = -3'sd2;
            MOVE_6:  off_y = -3'sd1;
            MOVE_7:  off_y = 3'sd1;
            default: off_y = 3'sd0;
        endcase
    endfunction

    // Signed landing coordinate so that steps off either edge stay detectable
    function automatic logic signed [3:0] shift_pos(input logic [2:0] pos,
                                                    input logic signed [2:0] off);
        return $signed({1'b0, pos}) + $signed({off[2], off});
    endfunction

endpackage

// File: rtl/tour_poss_moves.sv
// Combinational mask of knight moves from (xx,yy) that stay on the board and land on unvisited squares.
module tour_poss_moves
    import tour_pkg::*;
(
    input  logic [2:0] xx,
    input  logic [2:0] yy,
    input  board_t     board,
    output logic [7:0] poss
);

    logic signed [3:0] nx [8];
    logic signed [3:0] ny [8];

    always_comb begin
        poss = '0;
        for (int m = 0; m < 8; m++) begin
            nx[m] = shift_pos(xx, off_x(8'h01 << m));
            ny[m] = shift_pos(yy, off_y(8'h01 << m));
            if (nx[m] >= 0 && nx[m] <= 4 && ny[m] >= 0 && ny[m] <= 4) begin
                if (board[nx[m][2:0]][ny[m][2:0]] == 5'd0)
                    poss[m] = 1'b1;
            end
        end
    end

endmodule

// File: rtl/tour_logic.sv
// Backtracking knight's-tour search on a 5x5 board; the solved move list is read back through indx/move.
module tour_logic
    import tour_pkg::*;
(
    input  logic       clk,
    input  logic       rst,
    input  logic [2:0] x_start,
    input  logic [2:0] y_start,
    input  logic       go,
    output logic       done,
    input  logic [4:0] indx,
    output logic [7:0] move
);

    state_t     state;
    board_t     board;
    logic [2:0] xx;
    logic [2:0] yy;
    logic [4:0] move_num;
    logic [7:0] poss_moves [0:23];
    logic [7:0] last_move  [0:23];
    logic [7:0] move_try;
    logic       update_position;

    logic [7:0] poss_now;
    logic [2:0] next_x;
    logic [2:0] next_y;
    logic [2:0] prev_x;
    logic [2:0] prev_y;
    logic [7:0] undone;

    tour_poss_moves u_poss (
        .xx    (xx),
        .yy    (yy),
        .board (board),
        .poss  (poss_now)
    );

    // Landing square is only used once the move is known legal, so 3-bit wrap is harmless
    assign next_x = xx + $unsigned(off_x(move_try));
    assign next_y = yy + $unsigned(off_y(move_try));
    assign undone = (move_num == 5'd0) ? 8'h00 : last_move[move_num - 5'd1];
    assign prev_x = xx - $unsigned(off_x(undone));
    assign prev_y = yy - $unsigned(off_y(undone));

    assign move = (indx <= LAST_MOVE) ? last_move[indx] : 8'h00;

    always_ff @(posedge clk) begin
        if (rst) begin
            state           <= IDLE;
            done            <= 1'b0;
            move_num        <= '0;
            board           <= '0;
            xx              <= '0;
            yy              <= '0;
            move_try        <= MOVE_0;
            update_position <= 1'b0;
            for (int i = 0; i < 24; i++) begin
                poss_moves[i] <= '0;
                last_move[i]  <= '0;
            end
        end else begin
            update_position <= 1'b0;
            case (state)
                IDLE: begin
                    if (go) begin
                        board    <= '0;
                        move_num <= '0;
                        done     <= 1'b0;
                        // An off-board start simply leaves the solver idle with no tour
                        if (x_start <= BOARD_MAX && y_start <= BOARD_MAX) begin
                            board[x_start][y_start] <= 5'd1;
                            xx    <= x_start;
                            yy    <= y_start;
                            state <= POSSIBLE;
                        end
                    end
                end
                POSSIBLE: begin
                    poss_moves[move_num] <= poss_now;
                    move_try             <= MOVE_0;
                    state                <= MAKE_MOVE;
                end
                MAKE_MOVE: begin
                    if (|(poss_moves[move_num] & move_try)) begin
                        update_position       <= 1'b1;
                        xx                    <= next_x;
                        yy                    <= next_y;
                        board[next_x][next_y] <= move_num + 5'd2;
                        last_move[move_num]   <= move_try;
                        if (move_num == LAST_MOVE) begin
                            done  <= 1'b1;
                            state <= IDLE;
                        end else begin
                            move_num <= move_num + 5'd1;
                            state    <= POSSIBLE;
                        end
                    end else if (move_try != MOVE_7) begin
                        move_try <= move_try << 1;
                    end else begin
                        state <= BACKUP;
                    end
                end
                BACKUP: begin
                    // poss_moves of the level we return to is still valid: deeper squares are cleared
                    board[xx][yy] <= 5'd0;
                    if (move_num == 5'd0) begin
                        state <= IDLE;
                    end else begin
                        xx       <= prev_x;
                        yy       <= prev_y;
                        move_num <= move_num - 5'd1;
                        if (undone != MOVE_7) begin
                            move_try <= undone << 1;
                            state    <= MAKE_MOVE;
                        end
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_tour_logic.sv
// Self-checking bench for tour_logic: a depth-first reference search predicts the exact tour found.
module tb_tour_logic;

    logic       clk = 1'b0;
    logic       rst;
    logic       go;
    logic [2:0] x_start;
    logic [2:0] y_start;
    logic       done;
    logic [4:0] indx;
    logic [7:0] move;

    int total = 0;
    int bad   = 0;

    localparam int SOLVE_LIMIT = 8_000_000;

    int dxs[8] = '{1, -1, -2, -2, -1, 1, 2, 2};
    int dys[8] = '{2, 2, 1, -1, -2, -2, -1, 1};
    int ref_moves[24];
    bit ref_found;

    tour_logic dut (
        .clk     (clk),
        .rst     (rst),
        .x_start (x_start),
        .y_start (y_start),
        .go      (go),
        .done    (done),
        .indx    (indx),
        .move    (move)
    );

    always #5 clk = ~clk;

    task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("[TB] FAIL %s: got=%0h expected=%0h", tag, got, exp);
        end
    endtask

    task automatic applyStimulus(input logic r, input logic g, input logic [2:0] x, input logic [2:0] y);
        rst = r;
        go = g;
        x_start = x;
        y_start = y;
        @(negedge clk);
    endtask

    // Plain depth-first search over squares, trying moves in index order
    task automatic modelTour(input int sx, input int sy);
        int vis[5][5];
        int px[25];
        int py[25];
        int next_try[25];
        int depth;
        int nx;
        int ny;
        bit advanced;
        bit exhausted;
        foreach (vis[i, j]) vis[i][j] = 0;
        px[0] = sx;
        py[0] = sy;
        vis[sx][sy] = 1;
        depth = 0;
        next_try[0] = 0;
        ref_found = 0;
        exhausted = 0;
        while (!ref_found && !exhausted) begin
            if (depth == 24) begin
                ref_found = 1;
            end else begin
                advanced = 0;
                for (int k = next_try[depth]; k < 8 && !advanced; k++) begin
                    nx = px[depth] + dxs[k];
                    ny = py[depth] + dys[k];
                    if (nx >= 0 && nx <= 4 && ny >= 0 && ny <= 4 && vis[nx][ny] == 0) begin
                        ref_moves[depth] = k;
                        next_try[depth] = k + 1;
                        px[depth+1] = nx;
                        py[depth+1] = ny;
                        vis[nx][ny] = 1;
                        advanced = 1;
                    end
                end
                if (advanced) begin
                    depth++;
                    next_try[depth] = 0;
                end else if (depth == 0) begin
                    exhausted = 1;
                end else begin
                    vis[px[depth]][py[depth]] = 0;
                    depth--;
                end
            end
        end
    endtask

    function automatic logic [7:0] modelMask(input int x, input int y);
        logic [7:0] m = '0;
        for (int k = 0; k < 8; k++)
            if (x + dxs[k] >= 0 && x + dxs[k] <= 4 && y + dys[k] >= 0 && y + dys[k] <= 4)
                m[k] = 1'b1;
        return m;
    endfunction

    function automatic int boardNonZero();
        int n = 0;
        for (int x = 0; x < 5; x++)
            for (int y = 0; y < 5; y++)
                if (dut.board[x][y] != 5'd0) n++;
        return n;
    endfunction

    task automatic waitDone(input string tag, input bit toggle_go);
        int n = 0;
        while (!done && n < SOLVE_LIMIT) begin
            if (toggle_go) go = 1'($urandom_range(0, 1));
            @(negedge clk);
            n++;
        end
        go = 1'b0;
        checkOutput(tag, done, 1);
    endtask

    task automatic checkTour(input int sx, input int sy, input string tag);
        int  cnt[26];
        int  pos_x[26];
        int  pos_y[26];
        int  v;
        int  adx;
        int  ady;
        int  cx;
        int  cy;
        int  m_idx;
        int  seen[5][5];
        bit  perm_ok = 1;
        bit  adj_ok = 1;
        bit  replay_ok = 1;
        foreach (cnt[i]) cnt[i] = 0;
        foreach (seen[i, j]) seen[i][j] = 0;
        for (int x = 0; x < 5; x++)
            for (int y = 0; y < 5; y++) begin
                v = int'(dut.board[x][y]);
                if (v >= 1 && v <= 25) begin
                    cnt[v]++;
                    pos_x[v] = x;
                    pos_y[v] = y;
                end else perm_ok = 0;
            end
        for (int k = 1; k <= 25; k++) if (cnt[k] != 1) perm_ok = 0;
        checkOutput({tag, "_perm"}, 32'(perm_ok), 1);
        checkOutput({tag, "_start"}, 32'(dut.board[sx][sy]), 1);
        if (!perm_ok) adj_ok = 0;
        else
            for (int k = 1; k < 25; k++) begin
                adx = (pos_x[k+1] > pos_x[k]) ? pos_x[k+1] - pos_x[k] : pos_x[k] - pos_x[k+1];
                ady = (pos_y[k+1] > pos_y[k]) ? pos_y[k+1] - pos_y[k] : pos_y[k] - pos_y[k+1];
                if (adx * ady != 2) adj_ok = 0;
            end
        checkOutput({tag, "_adjacent"}, 32'(adj_ok), 1);
        cx = sx;
        cy = sy;
        seen[cx][cy] = 1;
        for (int i = 0; i < 24; i++) begin
            indx = 5'(i);
            #1;
            checkOutput($sformatf("%s_move%0d", tag, i), 32'(move), 32'(1) << ref_moves[i]);
            m_idx = 0;
            for (int b = 0; b < 8; b++) if (move[b]) m_idx = b;
            if ($countones(move) != 1) replay_ok = 0;
            else begin
                cx += dxs[m_idx];
                cy += dys[m_idx];
                if (cx < 0 || cx > 4 || cy < 0 || cy > 4 || seen[cx][cy] != 0) begin
                    replay_ok = 0;
                    cx = sx;
                    cy = sy;
                end else seen[cx][cy] = 1;
            end
        end
        checkOutput({tag, "_replay"}, 32'(replay_ok), 1);
        indx = 5'd24;
        #1;
        checkOutput({tag, "_indx24"}, 32'(move), 0);
        @(negedge clk);
    endtask

    initial begin
        int ri;
        int bx;
        int by;
        int upd_seen;
        rst = 1'b1;
        go = 1'b0;
        x_start = '0;
        y_start = '0;
        indx = '0;
        @(negedge clk);

        // Reset with go asserted must keep everything quiet
        for (int i = 0; i < 2; i++) begin
            applyStimulus(1'b1, 1'b1, 3'd0, 3'd0);
            checkOutput("rst_done", 32'(done), 0);
            checkOutput("rst_update", 32'(dut.update_position), 0);
        end
        checkOutput("rst_board", 32'(boardNonZero()), 0);
        applyStimulus(1'b0, 1'b0, 3'd0, 3'd0);
        checkOutput("idle_done", 32'(done), 0);

        modelTour(0, 0);
        applyStimulus(1'b0, 1'b1, 3'd0, 3'd0);
        go = 1'b0;
        checkOutput("go_board00", 32'(dut.board[0][0]), 1);
        checkOutput("go_done", 32'(done), 0);
        @(negedge clk);
        checkOutput("poss_first", 32'(dut.poss_moves[0]), 32'(modelMask(0, 0)));
        waitDone("solve00_done", 1'b0);
        checkTour(0, 0, "t00");

        // Second go after done, held high throughout the search
        applyStimulus(1'b0, 1'b1, 3'd0, 3'd0);
        checkOutput("rego_done_drop", 32'(done), 0);
        waitDone("resolve00_done", 1'b0);
        checkTour(0, 0, "t00b");

        modelTour(2, 2);
        applyStimulus(1'b0, 1'b1, 3'd2, 3'd2);
        go = 1'b0;
        checkOutput("go_board22", 32'(dut.board[2][2]), 1);
        waitDone("solve22_done", 1'b1);
        checkTour(2, 2, "t22");

        // Reset part-way through a search
        modelTour(0, 0);
        applyStimulus(1'b0, 1'b1, 3'd0, 3'd0);
        go = 1'b0;
        repeat (1000) @(negedge clk);
        applyStimulus(1'b1, 1'b0, 3'd0, 3'd0);
        checkOutput("midrst_done", 32'(done), 0);
        checkOutput("midrst_board", 32'(boardNonZero()), 0);
        indx = 5'd0;
        #1;
        checkOutput("midrst_move0", 32'(move), 0);
        @(negedge clk);
        applyStimulus(1'b0, 1'b1, 3'd0, 3'd0);
        go = 1'b0;
        waitDone("after_rst_done", 1'b1);
        checkTour(0, 0, "t00c");

        for (int i = 0; i < 10; i++) begin
            ri = $urandom_range(0, 31);
            indx = 5'(ri);
            #1;
            checkOutput($sformatf("rand_indx%0d", ri), 32'(move),
                        (ri <= 23) ? (32'(1) << ref_moves[ri]) : 32'(0));
        end
        @(negedge clk);

        // Off-board start squares give no tour and never start moving
        for (int i = 0; i < 4; i++) begin
            bx = $urandom_range(0, 7);
            by = $urandom_range(5, 7);
            if ($urandom_range(0, 1) == 1) begin
                ri = bx;
                bx = by;
                by = ri;
            end
            applyStimulus(1'b0, 1'b1, 3'(bx), 3'(by));
            go = 1'b0;
            checkOutput($sformatf("bad_start_done_%0d_%0d", bx, by), 32'(done), 0);
            upd_seen = 0;
            repeat (5) begin
                @(negedge clk);
                if (dut.update_position) upd_seen++;
            end
            checkOutput("bad_start_board", 32'(boardNonZero()), 0);
            checkOutput("bad_start_update", 32'(upd_seen), 0);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
